// File: rtl/calc_pkg.sv
// Shared calculator constants and types used by the button front-end.
package calc_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 8;
  localparam int REPEAT_DELAY_DEFAULT    = 500;
  localparam int REPEAT_PERIOD_DEFAULT   = 100;
  localparam int KEYPAD_BUTTONS          = 16;

  typedef logic [$clog2(KEYPAD_BUTTONS)-1:0] btn_code_t;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: two-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted rising edge.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The counter only advances while s2 disagrees with level, so it never
  // passes CNT_LAST; any return to agreement discards the partial count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= s2_q;
        press_q <= s2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounced levels, press pulses and a lowest-index press code for N buttons.
// Optional auto-repeat of the last coded button: BUTTON_CONDITIONER_REPEAT_EN.
module button_conditioner
  import calc_pkg::*;
#(
  parameter int NUM_BUTTONS     = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_BUTTONS-1:0]         raw_i,
  output logic [NUM_BUTTONS-1:0]         level_o,
  output logic [NUM_BUTTONS-1:0]         press_o,
  output logic [$clog2(NUM_BUTTONS)-1:0] code_o,
  output logic                           code_valid_o,
  output logic                           multi_o
);

  localparam int CODE_W = $clog2(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] level_w;
  logic [NUM_BUTTONS-1:0] chan_press_w;
  logic [NUM_BUTTONS-1:0] rpt_vec_w;
  logic [NUM_BUTTONS-1:0] press_w;
  logic [CODE_W-1:0]      code_d;
  logic                   multi_d;
  logic [CODE_W-1:0]      code_q;
  logic                   code_valid_q;
  logic                   multi_q;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (raw_i[gi]),
      .level_o(level_w[gi]),
      .press_o(chan_press_w[gi])
    );
  end

  assign press_w = chan_press_w | rpt_vec_w;

  always_comb begin
    code_d = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (press_w[i]) code_d = CODE_W'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign multi_d = |(press_w & (press_w - 1'b1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      code_q       <= '0;
      code_valid_q <= 1'b0;
      multi_q      <= 1'b0;
    end else if (|press_w) begin
      code_q       <= code_d;
      code_valid_q <= 1'b1;
      multi_q      <= multi_d;
    end else begin
      code_valid_q <= 1'b0;
      multi_q      <= 1'b0;
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(RPT_MAX + 1);

  logic              rpt_active_q;
  logic              rpt_pulse_q;
  logic [CODE_W-1:0] rpt_ch_q;
  logic [RCW-1:0]    rpt_cnt_q;
  logic [RCW-1:0]    rpt_target_q;
  logic              rpt_fire;
  logic              rpt_won;

  // Masking by the live level makes a release suppress an already-armed pulse.
  assign rpt_fire = rpt_pulse_q & level_w[rpt_ch_q];
  assign rpt_won  = rpt_fire && (code_d == rpt_ch_q);

  always_comb begin
    rpt_vec_w = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rpt_vec_w[i] = rpt_fire && (rpt_ch_q == CODE_W'(i));
    end
  end

  // The counter reads 1 in the cycle after a coded press, so the pulse is
  // armed when it reaches target-1 and lands exactly target cycles later.
  // A repeat that wins the encoder reloads with the period, anything else
  // that wins restarts the initial delay on the new channel.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rpt_active_q <= 1'b0;
      rpt_pulse_q  <= 1'b0;
      rpt_ch_q     <= '0;
      rpt_cnt_q    <= '0;
      rpt_target_q <= '0;
    end else begin
      rpt_pulse_q <= 1'b0;
      if (|press_w) begin
        rpt_active_q <= 1'b1;
        rpt_ch_q     <= code_d;
        rpt_cnt_q    <= RCW'(1);
        rpt_target_q <= rpt_won ? RCW'(REPEAT_PERIOD) : RCW'(REPEAT_DELAY);
      end else if (rpt_active_q && !level_w[rpt_ch_q]) begin
        rpt_active_q <= 1'b0;
        rpt_cnt_q    <= '0;
      end else if (rpt_active_q) begin
        rpt_cnt_q   <= rpt_cnt_q + 1'b1;
        rpt_pulse_q <= (rpt_cnt_q == rpt_target_q - 1'b1);
      end
    end
  end
`else
  assign rpt_vec_w = '0;
`endif

  // Repeat timings below two cycles cannot be produced by the registered pulse.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_repeat_unsupported
  end

  assign level_o      = level_w;
  assign press_o      = press_w;
  assign code_o       = code_q;
  assign code_valid_o = code_valid_q;
  assign multi_o      = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT 10/3.
module tb_button_conditioner;
  import calc_pkg::*;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  btn_code_t    code;
  logic         code_valid;
  logic         multi;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .raw_i       (raw),
    .level_o     (level),
    .press_o     (press),
    .code_o      (code),
    .code_valid_o(code_valid),
    .multi_o     (multi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    raw   = '0;
    tick(3);
    n_checks++;
    if ({level, press, code, code_valid, multi} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: level=%h press=%h code=%0d valid=%b multi=%b, required all 0",
               level, press, code, code_valid, multi);
    end
    rst_n = 1'b1;
    tick(2);
    $display("reset: outputs cleared");
  endtask

  task automatic test_clean_press;
    raw[5] = 1'b1;
    tick(5);
    n_checks++;
    if (level !== '0 || press !== '0) begin
      n_fail++;
      $display("FAIL clean_early: level=%h press=%h, required 0000 0000", level, press);
    end
    tick(1);
    n_checks++;
    if (level !== 16'h0020 || press !== 16'h0020) begin
      n_fail++;
      $display("FAIL clean_accept: level=%h press=%h, required 0020 0020", level, press);
    end
    tick(1);
    n_checks++;
    if (press !== '0 || code_valid !== 1'b1 || code !== 4'd5 || multi !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_code: press=%h valid=%b code=%0d multi=%b, required 0000 1 5 0",
               press, code_valid, code, multi);
    end
    raw[5] = 1'b0;
    tick(1);
    n_checks++;
    if (code_valid !== 1'b0 || code !== 4'd5) begin
      n_fail++;
      $display("FAIL clean_code_hold: valid=%b code=%0d, required 0 5", code_valid, code);
    end
    tick(10);
    $display("clean press ch5: code=%0d", code);
  endtask

  task automatic test_bounce;
    logic [3:0] seq = 4'b0101;
    int bad = 0;
    for (int s = 3; s >= 0; s--) begin
      raw[3] = seq[s] ? 1'b0 : 1'b1;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        if (press !== '0 || level !== '0) bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet: %0d cycles with activity, required 0", bad);
    end
    raw[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      n_checks++;
      if (press !== ((k == 6) ? 16'h0008 : 16'h0000)) begin
        n_fail++;
        $display("FAIL bounce_pulse_k%0d: press=%h, required %h", k, press,
                 (k == 6) ? 16'h0008 : 16'h0000);
      end
    end
    raw[3] = 1'b0;
    tick(10);
    $display("bounce ch3: single pulse after final rise");
  endtask

  task automatic test_simultaneous;
    raw[2] = 1'b1;
    raw[9] = 1'b1;
    tick(6);
    n_checks++;
    if (press !== 16'h0204) begin
      n_fail++;
      $display("FAIL simul_press: press=%h, required 0204", press);
    end
    raw[2] = 1'b0;
    raw[9] = 1'b0;
    tick(1);
    n_checks++;
    if (press !== '0 || code !== 4'd2 || code_valid !== 1'b1 || multi !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_code: press=%h code=%0d valid=%b multi=%b, required 0000 2 1 1",
               press, code, code_valid, multi);
    end
    tick(10);
    $display("simultaneous ch2+ch9: code=%0d multi seen", code);
  endtask

  task automatic test_release_reset;
    raw[7] = 1'b1;
    tick(6);
    n_checks++;
    if (press !== 16'h0080 || level !== 16'h0080) begin
      n_fail++;
      $display("FAIL rel_accept: press=%h level=%h, required 0080 0080", press, level);
    end
    raw[7] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_checks++;
      if (press !== '0 || level[7] !== (k < 6)) begin
        n_fail++;
        $display("FAIL rel_fall_k%0d: press=%h level7=%b, required 0000 %b", k, press, level[7], k < 6);
      end
    end
    tick(2);
    raw[7] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    n_checks++;
    if ({level, press, code, code_valid, multi} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: level=%h press=%h code=%0d valid=%b multi=%b, required all 0",
               level, press, code, code_valid, multi);
    end
    tick(1);
    rst_n = 1'b1;
    tick(5);
    n_checks++;
    if (press !== '0 || level !== '0) begin
      n_fail++;
      $display("FAIL postreset_early: press=%h level=%h, required 0000 0000", press, level);
    end
    tick(1);
    n_checks++;
    if (press !== 16'h0080 || level !== 16'h0080) begin
      n_fail++;
      $display("FAIL postreset_press: press=%h level=%h, required 0080 0080", press, level);
    end
    raw[7] = 1'b0;
    tick(10);
    $display("release/reset ch7: repress accepted after reset release");
  endtask

  task automatic test_repeat;
    logic [N-1:0] exp_press;
    raw[0] = 1'b1;
    tick(6);
    for (int off = 0; off <= 30; off++) begin
      exp_press = '0;
      if (off == 0) exp_press = 16'h0001;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      if (off == 10 || off == 13 || off == 16 || off == 19 || off == 22) exp_press = 16'h0001;
`endif
      n_checks++;
      if (press !== exp_press) begin
        n_fail++;
        $display("FAIL repeat_off%0d: press=%h, required %h", off, press, exp_press);
      end
      if (off == 22 || off == 23) begin
        n_checks++;
        if (level[0] !== (off == 22)) begin
          n_fail++;
          $display("FAIL repeat_level_off%0d: level0=%b, required %b", off, level[0], off == 22);
        end
      end
      if (off == 17) raw[0] = 1'b0;
      tick(1);
    end
    $display("repeat ch0: pulse pattern checked over 31 cycles");
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_simultaneous;
    test_release_reset;
    test_repeat;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
